// File: rtl/shift_right_seq_if.sv
// rtl/shift_right_seq_if.sv - request/result bundle for the iterative right shifter
//
// Purpose: groups the start/operand request and the busy/done/y result of
// shift_right_seq so the ALU execute stage and the shifter share one bundle.
// Signals:
//   start  : request pulse (master -> slave)
//   A      : WIDTH-bit operand (master -> slave)
//   bshift : SW-bit shift amount (master -> slave)
//   arith  : 1 = sign-fill, 0 = zero-fill (master -> slave)
//   busy   : shift in progress (slave -> master)
//   done   : one-cycle result-valid pulse (slave -> master)
//   y      : WIDTH-bit result register (slave -> master)
interface shift_right_seq_if #(
  parameter int WIDTH = 5,
  parameter int SW    = 2
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [SW-1:0]    bshift;
  logic             arith;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;

  modport master (
    output start, A, bshift, arith,
    input  busy, done, y
  );

  modport slave (
    input  start, A, bshift, arith,
    output busy, done, y
  );
endinterface

// File: rtl/shift_right_seq.sv
// rtl/shift_right_seq.sv - one-bit-per-clock right shifter with start/done handshake
//
// Purpose: shifts a WIDTH-bit operand right by bshift (0..2^SW-1) positions,
// one position per clock. Logical (zero-fill) always; arithmetic (sign-fill)
// when the build macro SHIFT_RIGHT_SEQ_ARITH_EN is defined. Without the macro
// the arith input is ignored and no sign-capture register exists.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : shift_right_seq_if.slave (start, A, bshift, arith in;
//           busy, done, y out)
// Latency is bshift + 1 cycles from the start cycle; a new start may be
// accepted in the DONE cycle, so back-to-back operations leave no gap.
module shift_right_seq #(
  parameter int WIDTH = 5,
  parameter int SW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  shift_right_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [WIDTH-1:0] y_q;
  logic [SW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             fill;

`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
  logic fill_q;
  assign fill = fill_q;
`else
  // Logical-only build: arith is kept on the bundle but never consumed.
  logic unused_arith;
  assign unused_arith = bus.arith;
  assign fill         = 1'b0;
`endif

  // Next working value: one position right, vacated MSB takes the fill bit.
  assign work_d = {fill, work_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        // IDLE and DONE are both "ready"; accepting in DONE gives back-to-back.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (bus.bshift == '0) begin
              // Zero shift bypasses SHIFT entirely and never raises busy.
              y_q     <= bus.A;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              work_q  <= bus.A;
              cnt_q   <= bus.bshift;
              busy_q  <= 1'b1;
              state_q <= SHIFT;
`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
              fill_q  <= bus.arith ? bus.A[WIDTH-1] : 1'b0;
`endif
            end
          end else begin
            state_q <= IDLE;
          end
        end

        // start is deliberately not looked at here: requests during a shift drop.
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - SW'(1);
          if (cnt_q == SW'(1)) begin
            y_q     <= work_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// tb/tb_shift_right_seq.sv - directed self-checking bench for shift_right_seq
module tb_shift_right_seq;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [4:0] exp_arith_b2;
  logic [4:0] exp_b2b;

  shift_right_seq_if #(.WIDTH(5), .SW(2)) bus ();

  shift_right_seq #(.WIDTH(5), .SW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then settle 1 time unit past it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [4:0] a, input logic [1:0] b, input logic ar);
    bus.start  = s;
    bus.A      = a;
    bus.bshift = b;
    bus.arith  = ar;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
    exp_arith_b2 = 5'b11101;
    exp_b2b      = 5'b11110;
`else
    exp_arith_b2 = 5'b00101;
    exp_b2b      = 5'b00010;
`endif

    reset = 1'b1;
    drive(1'b0, 5'b0, 2'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_y",    8'(bus.y),    8'd0);

    // Logical shift by 2: busy two cycles, done on the third.
    drive(1'b1, 5'b10110, 2'd2, 1'b0);
    tick();
    drive(1'b0, 5'b00000, 2'd0, 1'b0);
    chk("log_busy1", 8'(bus.busy), 8'd1);
    chk("log_done1", 8'(bus.done), 8'd0);
    chk("log_yhold", 8'(bus.y),    8'd0);
    tick();
    chk("log_busy2", 8'(bus.busy), 8'd1);
    chk("log_done2", 8'(bus.done), 8'd0);
    tick();
    chk("log_done3", 8'(bus.done), 8'd1);
    chk("log_busy3", 8'(bus.busy), 8'd0);
    chk("log_y",     8'(bus.y),    8'b00101);
    tick();
    chk("log_done_pulse", 8'(bus.done), 8'd0);
    chk("log_y_stable",   8'(bus.y),    8'b00101);

    // Arithmetic request with the same operand.
    drive(1'b1, 5'b10110, 2'd2, 1'b1);
    tick();
    drive(1'b0, 5'b00000, 2'd0, 1'b0);
    tick();
    tick();
    chk("ar_done", 8'(bus.done), 8'd1);
    chk("ar_y",    8'(bus.y),    8'(exp_arith_b2));
    tick();

    // Zero shift: done next cycle, busy never asserted.
    drive(1'b1, 5'b01011, 2'd0, 1'b0);
    tick();
    drive(1'b0, 5'b00000, 2'd0, 1'b0);
    chk("z_done", 8'(bus.done), 8'd1);
    chk("z_busy", 8'(bus.busy), 8'd0);
    chk("z_y",    8'(bus.y),    8'b01011);

    // Back-to-back start in the DONE cycle; mid-shift start and operand changes ignored.
    drive(1'b1, 5'b10000, 2'd3, 1'b1);
    tick();
    drive(1'b1, 5'b11111, 2'd1, 1'b0);
    chk("b2b_busy1", 8'(bus.busy), 8'd1);
    chk("b2b_done1", 8'(bus.done), 8'd0);
    chk("b2b_yhold", 8'(bus.y),    8'b01011);
    tick();
    drive(1'b0, 5'b00000, 2'd0, 1'b0);
    chk("b2b_busy2", 8'(bus.busy), 8'd1);
    tick();
    chk("b2b_busy3", 8'(bus.busy), 8'd1);
    chk("b2b_done3", 8'(bus.done), 8'd0);
    tick();
    chk("b2b_done4", 8'(bus.done), 8'd1);
    chk("b2b_busy4", 8'(bus.busy), 8'd0);
    chk("b2b_y",     8'(bus.y),    8'(exp_b2b));
    tick();
    chk("b2b_idle_done", 8'(bus.done), 8'd0);

    // Reset held two cycles mid-shift, with a coinciding start that must drop.
    drive(1'b1, 5'b10110, 2'd3, 1'b0);
    tick();
    drive(1'b0, 5'b00000, 2'd0, 1'b0);
    tick();
    reset = 1'b1;
    drive(1'b1, 5'b01011, 2'd0, 1'b0);
    tick();
    chk("mid_rst_busy", 8'(bus.busy), 8'd0);
    chk("mid_rst_done", 8'(bus.done), 8'd0);
    chk("mid_rst_y",    8'(bus.y),    8'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 5'b00000, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("post_rst_done%0d", i), 8'(bus.done), 8'd0);
      chk($sformatf("post_rst_busy%0d", i), 8'(bus.busy), 8'd0);
      tick();
    end
    chk("post_rst_y", 8'(bus.y), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
